// File: rtl/usb_crc16_gen_if.sv
// Bus bundle for the USB transmit CRC-16 generator.
//
// Handshake semantics:
//   - d_valid qualifies d_in for exactly one cycle. Each high cycle is one payload bit.
//   - data_done marks the end of the payload. A bit presented in the same cycle is
//     still part of the payload.
//   - While crc_out_valid is high, crc_out holds the current CRC bit.
//   - tx_shift is the downstream acceptance of crc_out. crc_out advances only on a
//     cycle with tx_shift high and holds otherwise.
//   - crc_sent pulses for one cycle once the last of the 16 CRC bits has been accepted.
interface usb_crc16_gen_if;
    logic       init;
    logic       d_in;
    logic       d_valid;
    logic       data_done;
    logic       tx_shift;
    logic       crc_out;
    logic       crc_out_valid;
    logic       busy;
    logic       crc_sent;
    logic [1:0] dbg_state;

    modport master (
        output init, d_in, d_valid, data_done, tx_shift,
        input  crc_out, crc_out_valid, busy, crc_sent, dbg_state
    );

    modport slave (
        input  init, d_in, d_valid, data_done, tx_shift,
        output crc_out, crc_out_valid, busy, crc_sent, dbg_state
    );
endinterface

// File: rtl/usb_crc16_gen.sv
// Transmit-side USB CRC-16 generator (x^16+x^15+x^2+1).
// The block accumulates payload bits serially into crc[0:15], with feedback taken
// from crc[15]. It then shifts the field out MSB (crc[15]) first, one bit per
// downstream tx_shift strobe.
// USB_MODE 0: zero seed, field sent as-is.
// USB_MODE 1: all-ones seed, field sent complemented.
module usb_crc16_gen #(
    parameter int USB_MODE = 0
) (
    input  logic           clk,
    input  logic           n_rst,
    usb_crc16_gen_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic [15:0] SEED    = (USB_MODE != 0) ? 16'hFFFF : 16'h0000;
    localparam logic        OUT_INV = (USB_MODE != 0);

    state_t      state, state_nx;
    logic [15:0] crc, crc_nx;
    logic [3:0]  bit_cnt, bit_cnt_nx;
    logic        crc_sent_q, crc_sent_nx;
    logic        fb;

    assign fb = bus.d_in ^ crc[15];

    // Register all state; asynchronous reset returns the block to IDLE with a clear CRC.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            crc        <= 16'h0000;
            bit_cnt    <= 4'd0;
            crc_sent_q <= 1'b0;
        end else begin
            state      <= state_nx;
            crc        <= crc_nx;
            bit_cnt    <= bit_cnt_nx;
            crc_sent_q <= crc_sent_nx;
        end
    end

    // Next-state and datapath. init overrides everything, including an in-flight SEND.
    always_comb begin
        state_nx    = state;
        crc_nx      = crc;
        bit_cnt_nx  = bit_cnt;
        crc_sent_nx = 1'b0;
        if (bus.init) begin
            state_nx   = ACCUM;
            crc_nx     = SEED;
            bit_cnt_nx = 4'd0;
        end else begin
            case (state)
                ACCUM: begin
                    // A bit presented with data_done is folded in before the append starts.
                    if (bus.d_valid) begin
                        crc_nx = {crc[14] ^ fb, crc[13:2], crc[1] ^ fb, crc[0], fb};
                    end
                    if (bus.data_done) begin
                        state_nx   = SEND;
                        bit_cnt_nx = 4'd0;
                    end
                end
                SEND: begin
                    if (bus.tx_shift) begin
                        crc_nx     = {crc[14:0], 1'b0};
                        bit_cnt_nx = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            state_nx    = IDLE;
                            crc_sent_nx = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Output decode: driven straight from the registers, so reset clears it immediately.
    always_comb begin
        bus.crc_out       = (state == SEND) ? (crc[15] ^ OUT_INV) : 1'b0;
        bus.crc_out_valid = (state == SEND);
        bus.busy          = (state != IDLE);
        bus.crc_sent      = crc_sent_q;
        bus.dbg_state     = state;
    end

endmodule

// File: tb/tb_usb_crc16_gen.sv
// Bench for usb_crc16_gen.
// One instance per USB_MODE. A table of packets is followed by randomised
// packets and by hand-written abort and reset sequences. Expected CRC bits are
// queued when data_done is driven and popped as each tx_shift strobe consumes a bit.
module tb_usb_crc16_gen;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   sel = 0;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    usb_crc16_gen_if if0();
    usb_crc16_gen_if if1();

    usb_crc16_gen #(.USB_MODE(0)) dut0 (.clk(clk), .n_rst(n_rst), .bus(if0));
    usb_crc16_gen #(.USB_MODE(1)) dut1 (.clk(clk), .n_rst(n_rst), .bus(if1));

    logic       crc_out_s, valid_s, busy_s, sent_s;
    logic [1:0] dbg_s;
    assign crc_out_s = (sel == 1) ? if1.crc_out       : if0.crc_out;
    assign valid_s   = (sel == 1) ? if1.crc_out_valid : if0.crc_out_valid;
    assign busy_s    = (sel == 1) ? if1.busy          : if0.busy;
    assign sent_s    = (sel == 1) ? if1.crc_sent      : if0.crc_sent;
    assign dbg_s     = (sel == 1) ? if1.dbg_state     : if0.dbg_state;

    typedef struct {
        int          mode;
        int          len;
        logic [31:0] payload;
        int          gap;
        bit          merge;
        logic [15:0] exp_field;
    } vec_t;

    vec_t vecs[9];

    // One serial step of the reference CRC: bit i of c is crc[i].
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        logic        f;
        logic [15:0] n;
        f = d ^ c[15];
        n = {c[14:0], f};
        n[2]  = n[2] ^ f;
        n[15] = n[15] ^ f;
        return n;
    endfunction

    function automatic logic [15:0] model_field(input int mode, input int len, input logic [31:0] p);
        logic [15:0] c;
        c = (mode == 1) ? 16'hFFFF : 16'h0000;
        for (int i = 0; i < len; i++) c = crc_step(c, p[i]);
        return (mode == 1) ? ~c : c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the selected instance and keep the other one quiet.
    task automatic drive(input logic i, input logic d, input logic dv, input logic dd, input logic ts);
        if (sel == 1) begin
            if1.init = i; if1.d_in = d; if1.d_valid = dv; if1.data_done = dd; if1.tx_shift = ts;
            if0.init = 0; if0.d_in = 0; if0.d_valid = 0; if0.data_done = 0; if0.tx_shift = 0;
        end else begin
            if0.init = i; if0.d_in = d; if0.d_valid = dv; if0.data_done = dd; if0.tx_shift = ts;
            if1.init = 0; if1.d_in = 0; if1.d_valid = 0; if1.data_done = 0; if1.tx_shift = 0;
        end
    endtask

    task automatic start_packet(input int mode);
        sel = mode;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        check("init_state", dbg_s, 1);
        check("init_busy", busy_s, 1);
        check("init_valid", valid_s, 0);
    endtask

    task automatic feed(input int len, input logic [31:0] p, input bit merge);
        for (int i = 0; i < len; i++) begin
            if (merge && i == len - 1) drive(0, p[i], 1, 1, 0);
            else                       drive(0, p[i], 1, 0, 0);
            @(negedge clk);
        end
        if (!(merge && len > 0)) begin
            drive(0, 0, 0, 1, 0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        check("send_state", dbg_s, 2);
        check("send_valid", valid_s, 1);
    endtask

    // Strobe tx_shift once every gap cycles until `strobes` bits are consumed.
    task automatic drain(input int gap, input logic [15:0] field, input int strobes, output logic [15:0] seen);
        int cycles;
        int n;
        int budget;
        logic [0:0] e;
        cycles = 0;
        n = 0;
        budget = 16 * gap + 32;
        seen = 16'h0000;
        for (int b = 15; b >= 0; b--) exp_q.push_back(field[b]);
        while (n < strobes && cycles < budget && exp_q.size() > 0) begin
            check("crc_sent_early", sent_s, 0);
            if ((cycles % gap) == gap - 1) begin
                e = exp_q.pop_front();
                check($sformatf("crc_bit%0d", n), crc_out_s, e);
                seen = {seen[14:0], crc_out_s};
                drive(0, 0, 0, 0, 1);
                n++;
            end else begin
                check("crc_hold", crc_out_s, exp_q[0]);
                drive(0, 0, 0, 0, 0);
            end
            @(negedge clk);
            cycles++;
        end
        drive(0, 0, 0, 0, 0);
        if (n < strobes) check("drain_timeout", n, strobes);
        if (strobes == 16) begin
            check("crc_sent_pulse", sent_s, 1);
            check("busy_drop", busy_s, 0);
            check("end_idle", dbg_s, 0);
            check("end_valid", valid_s, 0);
            check("end_crc_out", crc_out_s, 0);
            @(negedge clk);
            check("crc_sent_once", sent_s, 0);
        end
        exp_q.delete();
    endtask

    task automatic residue(input int len, input logic [31:0] p, input logic [15:0] seen);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < len; i++) r = crc_step(r, p[i]);
        for (int b = 15; b >= 0; b--) r = crc_step(r, seen[b]);
        check("rx_residue", r, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seen;
        int          mode;
        int          len;
        int          gap;
        bit          merge;
        logic [31:0] p;

        vecs[0] = '{0, 1, 32'h1,  1, 1'b0, 16'h8005};
        vecs[1] = '{0, 1, 32'h1,  1, 1'b1, 16'h8005};
        vecs[2] = '{1, 0, 32'h0,  1, 1'b0, 16'h0000};
        vecs[3] = '{0, 1, 32'h1,  3, 1'b0, 16'h8005};
        vecs[4] = '{0, 2, 32'h3,  1, 1'b0, 16'h000A};
        vecs[5] = '{1, 1, 32'h1,  2, 1'b0, 16'h0001};
        vecs[6] = '{1, 1, 32'h0,  1, 1'b0, 16'h8004};
        vecs[7] = '{0, 0, 32'h0,  1, 1'b0, 16'h0000};
        vecs[8] = '{0, 8, 32'h0,  1, 1'b1, 16'h0000};

        // Reset values.
        sel = 0;
        drive(0, 0, 0, 0, 0);
        #12;
        check("rst_out0", {if0.crc_out, if0.crc_out_valid, if0.busy, if0.crc_sent}, 0);
        check("rst_out1", {if1.crc_out, if1.crc_out_valid, if1.busy, if1.crc_sent}, 0);
        check("rst_state0", if0.dbg_state, 0);
        check("rst_state1", if1.dbg_state, 0);
        @(negedge clk);
        n_rst = 1'b1;

        // Inputs other than init are ignored in IDLE.
        drive(0, 1, 1, 1, 1);
        repeat (3) @(negedge clk);
        drive(0, 0, 0, 0, 0);
        check("idle_ignore_state", dbg_s, 0);
        check("idle_ignore_sent", sent_s, 0);

        // Table-driven packets.
        for (int v = 0; v < 9; v++) begin
            start_packet(vecs[v].mode);
            feed(vecs[v].len, vecs[v].payload, vecs[v].merge);
            drain(vecs[v].gap, vecs[v].exp_field, 16, seen);
            if (vecs[v].mode == 0) residue(vecs[v].len, vecs[v].payload, seen);
        end

        // Random packets checked against the reference model.
        for (int k = 0; k < 8; k++) begin
            mode  = $urandom_range(0, 1);
            len   = $urandom_range(0, 32);
            gap   = $urandom_range(1, 3);
            merge = 1'($urandom_range(0, 1));
            p     = $urandom();
            start_packet(mode);
            feed(len, p, merge);
            drain(gap, model_field(mode, len, p), 16, seen);
            if (mode == 0) residue(len, p, seen);
        end

        // Asynchronous reset after 5 shifts of the CRC field.
        start_packet(0);
        feed(1, 32'h1, 1'b0);
        drain(1, 16'h8005, 5, seen);
        check("prerst_valid", valid_s, 1);
        n_rst = 1'b0;
        #1;
        check("rst_mid_crc_out", crc_out_s, 0);
        check("rst_mid_valid", valid_s, 0);
        check("rst_mid_busy", busy_s, 0);
        check("rst_mid_sent", sent_s, 0);
        check("rst_mid_state", dbg_s, 0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_sent", sent_s, 0);
        end

        // init at SEND bit 7 aborts the field and reseeds.
        start_packet(0);
        feed(1, 32'h1, 1'b0);
        drain(1, 16'h8005, 7, seen);
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        check("abort_state", dbg_s, 1);
        check("abort_valid", valid_s, 0);
        check("abort_crc_out", crc_out_s, 0);
        check("abort_sent", sent_s, 0);
        @(negedge clk);
        check("abort_no_sent", sent_s, 0);
        feed(8, 32'h0, 1'b0);
        drain(1, 16'h0000, 16, seen);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
